// File: rtl/store_mon_pkg.sv
// rtl/store_mon_pkg.sv - shared types and defaults for the store monitor
// Optional macro STORE_MON_TIMESTAMP_EN adds a timestamp field to each entry.
package store_mon_pkg;

  typedef logic [31:0] word_t;

  localparam word_t STORE_MON_DEF_ADDR = 32'h0000_0064;
  localparam word_t STORE_MON_DEF_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
`ifdef STORE_MON_TIMESTAMP_EN
    word_t ts;
`endif
    word_t data;
  } entry_t;

endpackage

// File: rtl/store_monitor_sync_fifo.sv
// rtl/store_monitor_sync_fifo.sv - synchronous FIFO with fall-through head and occupancy count
// Head reads as zero when empty so nothing stale is ever presented.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the push needs, so full-with-pop still accepts
  assign do_push = push & (~full | do_pop);

  assign head_valid = ~empty;
  assign head       = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - passive capture of stores to one memory-mapped word into a stream FIFO
// Optional macro STORE_MON_TIMESTAMP_EN adds a cycle counter and the out_ts port.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter int    DEPTH      = 8,
  parameter word_t MATCH_ADDR = STORE_MON_DEF_ADDR,
  parameter word_t MATCH_MASK = STORE_MON_DEF_MASK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            Adr,
  input  logic [31:0]            WriteData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
`ifdef STORE_MON_TIMESTAMP_EN
  ,
  output logic [31:0]            out_ts
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic   hit;
  logic   pop;
  logic   push;
  logic   full;
  entry_t wr_entry;
  entry_t head;

  assign hit  = MemWrite & ((Adr & MATCH_MASK) == (MATCH_ADDR & MATCH_MASK));
  assign pop  = out_valid & out_ready;
  assign full = (count == CW'(DEPTH));
  assign push = hit & (~full | pop);

`ifdef STORE_MON_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  assign out_ts = head.ts;
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = WriteData;
`ifdef STORE_MON_TIMESTAMP_EN
    wr_entry.ts   = ts_cnt;
`endif
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (wr_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (out_valid),
    .count      (count)
  );

  assign out_data = head.data;

  // the processor is never stalled, so a hit that finds no room is only counted
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (hit & ~push) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - self-checking bench for store_monitor against a queue-based model
// Timestamp checks are compiled in when STORE_MON_TIMESTAMP_EN is defined.
module tb_store_monitor;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef STORE_MON_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  logic [31:0] tq[$];
  bit          m_ovf;
  int          m_drops;
  logic [31:0] m_cyc;

  always #5 clk = ~clk;

  store_monitor #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Adr       (Adr),
    .WriteData (WriteData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef STORE_MON_TIMESTAMP_EN
    ,
    .out_ts    (out_ts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("out_valid", {31'b0, out_valid}, (n != 0) ? 32'd1 : 32'd0);
    chk("out_data", out_data, (n != 0) ? mq[0] : 32'h0);
    chk("count", {28'b0, count}, 32'(n));
    chk("overflow", {31'b0, overflow}, m_ovf ? 32'd1 : 32'd0);
    chk("drop_cnt", {16'b0, drop_cnt}, 32'(m_drops));
`ifdef STORE_MON_TIMESTAMP_EN
    chk("out_ts", out_ts, (n != 0) ? tq[0] : 32'h0);
`endif
  endtask

  function automatic void model_reset();
    mq.delete();
    tq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    m_cyc   = '0;
  endfunction

  // one clock edge of the intended behaviour: pop first, then the hit sees the freed room
  function automatic void model_edge();
    bit is_hit;
    if (reset) begin
      model_reset();
      return;
    end
    is_hit = MemWrite && ((Adr & 32'hFFFF_FFFC) == 32'h0000_0064);
    if (out_ready && mq.size() > 0) begin
      void'(mq.pop_front());
      void'(tq.pop_front());
    end
    if (is_hit) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(WriteData);
        tq.push_back(m_cyc);
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
    end
    m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic do_cycle(input logic rst, input logic mw, input logic [31:0] a,
                          input logic [31:0] d, input logic rdy);
    reset     = rst;
    MemWrite  = mw;
    Adr       = a;
    WriteData = d;
    out_ready = rdy;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [31:0] addr_pool [6];
    addr_pool[0] = 32'h64; addr_pool[1] = 32'h65; addr_pool[2] = 32'h67;
    addr_pool[3] = 32'h60; addr_pool[4] = 32'h68; addr_pool[5] = 32'h1064;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // idle after reset
    do_cycle(0, 0, 32'h0, 32'h0, 0);
    do_cycle(0, 0, 32'h64, 32'hDEAD, 1);

    // single hit, then a neighbouring non-matching store
    do_cycle(0, 1, 32'h64, 32'h7, 0);
    do_cycle(0, 1, 32'h60, 32'h99, 0);
    do_cycle(0, 0, 32'h0, 32'h0, 0);

    // fill from empty, overflow, then full-with-pop push of A5, then drain
    do_cycle(1, 0, 32'h0, 32'h0, 0);
    for (int i = 1; i <= 8; i++) do_cycle(0, 1, 32'h64, 32'(i), 0);
    do_cycle(0, 1, 32'h66, 32'h9, 0);
    do_cycle(0, 1, 32'h64, 32'hA5, 1);
    do_cycle(0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 32'h0, 32'h0, 1);

    // reset with occupancy 5 discards contents
    for (int i = 0; i < 5; i++) do_cycle(0, 1, 32'h64, 32'h100 + 32'(i), 0);
    do_cycle(1, 0, 32'h0, 32'h0, 0);
    do_cycle(0, 1, 32'h64, 32'h3C, 0);
    do_cycle(0, 0, 32'h0, 32'h0, 1);
    do_cycle(0, 0, 32'h0, 32'h0, 1);

    // hits spaced three cycles apart exercise timestamp spacing
    do_cycle(1, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 1, 32'h64, 32'h200 + 32'(i), 0);
      do_cycle(0, 0, 32'h0, 32'h0, 0);
      do_cycle(0, 0, 32'h0, 32'h0, 0);
    end
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 32'h0, 32'h0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r_mw;
      logic        r_rdy;
      logic        r_rst;
      logic [31:0] r_a;
      r_mw  = ($urandom_range(0, 99) < 60);
      r_rdy = ($urandom_range(0, 99) < 40);
      r_rst = ($urandom_range(0, 199) == 0);
      r_a   = ($urandom_range(0, 9) == 0) ? $urandom() : addr_pool[$urandom_range(0, 5)];
      do_cycle(r_rst, r_mw, r_a, $urandom(), r_rdy);
    end
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 32'h0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
